// File: rtl/i2c_codec_target.sv
// I2C write-only target for WM8731-style 3-byte register writes, with a local register file copy.
// States: IDLE bus free | ADDR/BYTE1/BYTE2 shifting a byte | ACK_A/ACK_1/ACK_2 driving ACK | IGNORE released until START/STOP
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 16,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_stb,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [6:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic       o_err
);
    localparam int         AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] LP_NUM_REGS = 7'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_IGNORE
    } state_t;

    logic       r_scl_s1, r_scl_s2, r_scl_prev;
    logic       r_sda_s1, r_sda_s2, r_sda_prev;
    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       w_lat1, w_lat2, w_commit;
    logic [6:0] r_reg;
    logic       r_d8;
    logic [7:0] r_dlo;
    logic       r_wr_stb;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic       r_err;
    logic [8:0] r_regs [NUM_REGS];
    logic [8:0] r_rd_data;

    // START/STOP need SCL high in both samples, so an SDA change coincident with an SCL edge is not a condition
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_in_byte;
    assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
    assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;
    assign w_in_byte  = (r_state == S_ADDR) || (r_state == S_BYTE1) || (r_state == S_BYTE2);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_sda_oe_nxt = r_sda_oe;
        w_lat1       = 1'b0;
        w_lat2       = 1'b0;
        w_commit     = 1'b0;
        if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
        end else if (w_scl_rise) begin
            if (w_in_byte && (r_cnt < 4'd8)) begin
                w_shift_nxt = {r_shift[6:0], r_sda_s2};
                w_cnt_nxt   = r_cnt + 4'd1;
            end
        end else if (w_scl_fall) begin
            case (r_state)
                S_ADDR: if (r_cnt == 4'd8) begin
                    if (r_shift == {DEV_ADDR, 1'b0}) begin
                        w_state_nxt  = S_ACK_A;
                        w_sda_oe_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IGNORE;
                    end
                end
                S_BYTE1: if (r_cnt == 4'd8) begin
                    w_state_nxt  = S_ACK_1;
                    w_sda_oe_nxt = 1'b1;
                    w_lat1       = 1'b1;
                end
                S_BYTE2: if (r_cnt == 4'd8) begin
                    w_state_nxt  = S_ACK_2;
                    w_sda_oe_nxt = 1'b1;
                    w_lat2       = 1'b1;
                end
                S_ACK_A: begin
                    w_state_nxt  = S_BYTE1;
                    w_cnt_nxt    = 4'd0;
                    w_sda_oe_nxt = 1'b0;
                end
                S_ACK_1: begin
                    w_state_nxt  = S_BYTE2;
                    w_cnt_nxt    = 4'd0;
                    w_sda_oe_nxt = 1'b0;
                end
                S_ACK_2: begin
                    w_state_nxt  = S_IGNORE;
                    w_sda_oe_nxt = 1'b0;
                    w_commit     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_prev <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_sda_oe   <= 1'b0;
        end else begin
            r_scl_s1   <= i_scl;
            r_scl_s2   <= r_scl_s1;
            r_scl_prev <= r_scl_s2;
            r_sda_s1   <= i_sda;
            r_sda_s2   <= r_sda_s1;
            r_sda_prev <= r_sda_s2;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_reg     <= 7'd0;
            r_d8      <= 1'b0;
            r_dlo     <= 8'd0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 7'd0;
            r_wr_data <= 9'd0;
            r_err     <= 1'b0;
            r_rd_data <= 9'd0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 9'd0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_lat1) {r_reg, r_d8} <= r_shift;
            if (w_lat2) r_dlo <= r_shift;
            if (w_commit) begin
                if ((r_reg == RESET_REG) && ({r_d8, r_dlo} == 9'd0)) begin
                    for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 9'd0;
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_reg;
                    r_wr_data <= {r_d8, r_dlo};
                end else if (r_reg < LP_NUM_REGS) begin
                    r_regs[r_reg[AW-1:0]] <= {r_d8, r_dlo};
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_reg;
                    r_wr_data <= {r_d8, r_dlo};
                end else begin
                    r_err <= 1'b1;
                end
            end
            r_rd_data <= (i_rd_addr < LP_NUM_REGS) ? r_regs[i_rd_addr[AW-1:0]] : 9'd0;
        end
    end

    assign o_sda_oe  = r_sda_oe;
    assign o_wr_stb  = r_wr_stb;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_rd_data = r_rd_data;
    assign o_busy    = (r_state != S_IDLE);
    assign o_err     = r_err;
endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench: a bit-banged I2C master drives the target; expected commits are queued and matched per strobe.
module tb_i2c_codec_target;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst, scl, sda_m;
    logic [6:0] rd_addr;
    logic       sda_oe, wr_stb, busy, err;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic       sda_bus;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    i2c_codec_target dut (
        .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_bus),
        .o_sda_oe(sda_oe), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy), .o_err(err)
    );

    typedef struct packed { logic [6:0] a; logic [8:0] d; } wr_t;
    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic oe_seen  = 1'b0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (!rst && wr_stb) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_strobe: observed addr 0x%0h data 0x%0h expected no strobe", wr_addr, wr_data);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk(32'(wr_addr), 32'(e.a), "strobe_addr");
                chk(32'(wr_data), 32'(e.d), "strobe_data");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        wait_n(2); sda_m = 1'b1; wait_n(H); scl = 1'b1; wait_n(H); sda_m = 1'b0; wait_n(H); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_n(2); sda_m = 1'b0; wait_n(H); scl = 1'b1; wait_n(H); sda_m = 1'b1; wait_n(H);
    endtask

    task automatic send_bit(input logic b);
        wait_n(2); sda_m = b; wait_n(H); scl = 1'b1; wait_n(H); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_n(2); sda_m = 1'b1; wait_n(H); scl = 1'b1; wait_n(2);
        chk(32'(sda_oe), 32'(exp_ack), tag);
        wait_n(H - 2); scl = 1'b0;
    endtask

    task automatic rd_check(input logic [6:0] a, input logic [8:0] e, input string tag);
        rd_addr = a;
        wait_n(1);
        chk(32'(rd_data), 32'(e), tag);
    endtask

    initial begin
        rst = 1'b1; scl = 1'b1; sda_m = 1'b1; rd_addr = 7'd4;
        wait_n(3);
        chk(32'(sda_oe), 0, "rst_sda_oe");
        chk(32'(wr_stb), 0, "rst_wr_stb");
        chk(32'(busy), 0, "rst_busy");
        chk(32'(err), 0, "rst_err");
        chk(32'(wr_addr), 0, "rst_wr_addr");
        chk(32'(wr_data), 0, "rst_wr_data");
        chk(32'(rd_data), 0, "rst_rd_data");
        rst = 1'b0;
        wait_n(3);

        // T1: basic write reg 4 = 0x012
        i2c_start();
        send_byte(8'h34, 1'b1, "t1_ack_addr");
        send_byte(8'h08, 1'b1, "t1_ack_b1");
        exp_q.push_back('{a: 7'h04, d: 9'h012});
        send_byte(8'h12, 1'b1, "t1_ack_b2");
        i2c_stop();
        rd_check(7'd4, 9'h012, "t1_read_reg4");

        // T4: truncated after byte 1
        i2c_start();
        wait_n(4);
        chk(32'(busy), 1, "t4_busy_after_start");
        send_byte(8'h34, 1'b1, "t4_ack_addr");
        send_byte(8'h08, 1'b1, "t4_ack_b1");
        i2c_stop();
        wait_n(4);
        chk(32'(busy), 0, "t4_busy_after_stop");
        rd_check(7'd4, 9'h012, "t4_reg4_unchanged");

        // T2: wrong device address
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'h36, 1'b0, "t2_nack_addr");
        send_byte(8'h08, 1'b0, "t2_nack_b1");
        send_byte(8'h99, 1'b0, "t2_nack_b2");
        i2c_stop();
        chk(32'(oe_seen), 0, "t2_sda_never_driven");
        rd_check(7'd4, 9'h012, "t2_reg4_unchanged");

        // T5: repeated START mid-byte 2
        i2c_start();
        send_byte(8'h34, 1'b1, "t5_ack_addr");
        send_byte(8'h08, 1'b1, "t5_ack_b1");
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_start();
        wait_n(4);
        chk(32'(sda_oe), 0, "t5_released_at_rstart");
        send_byte(8'h34, 1'b1, "t5_ack_addr2");
        send_byte(8'h0A, 1'b1, "t5_ack_b1_2");
        exp_q.push_back('{a: 7'h05, d: 9'h055});
        send_byte(8'h55, 1'b1, "t5_ack_b2_2");
        i2c_stop();
        rd_check(7'd4, 9'h012, "t5_reg4_partial_discarded");
        rd_check(7'd5, 9'h055, "t5_read_reg5");

        // T3: reg 2 = 0x1FF, then register-file reset
        exp_q.push_back('{a: 7'h02, d: 9'h1FF});
        i2c_start();
        send_byte(8'h34, 1'b1, "t3_ack_addr");
        send_byte(8'h05, 1'b1, "t3_ack_b1");
        send_byte(8'hFF, 1'b1, "t3_ack_b2");
        i2c_stop();
        rd_check(7'd2, 9'h1FF, "t3_read_reg2_set");
        exp_q.push_back('{a: 7'h0F, d: 9'h000});
        i2c_start();
        send_byte(8'h34, 1'b1, "t3_ack_addr_rst");
        send_byte(8'h1E, 1'b1, "t3_ack_b1_rst");
        send_byte(8'h00, 1'b1, "t3_ack_b2_rst");
        i2c_stop();
        rd_check(7'd2, 9'h000, "t3_read_reg2_cleared");
        rd_check(7'd5, 9'h000, "t3_read_reg5_cleared");

        // T6: write to invalid register 0x20
        i2c_start();
        send_byte(8'h34, 1'b1, "t6_ack_addr");
        send_byte(8'h40, 1'b1, "t6_ack_b1");
        send_byte(8'h01, 1'b1, "t6_ack_b2");
        send_byte(8'h77, 1'b0, "t6_nack_extra");
        i2c_stop();
        chk(32'(err), 1, "t6_err_set");
        chk(32'(wr_addr), 32'h0F, "t6_wr_addr_held");
        rd_check(7'h20, 9'h000, "t6_read_invalid");
        exp_q.push_back('{a: 7'h01, d: 9'h003});
        i2c_start();
        send_byte(8'h34, 1'b1, "t6_ack_addr_v");
        send_byte(8'h02, 1'b1, "t6_ack_b1_v");
        send_byte(8'h03, 1'b1, "t6_ack_b2_v");
        i2c_stop();
        chk(32'(err), 1, "t6_err_sticky");
        rd_check(7'd1, 9'h003, "t6_read_reg1");

        // Reset during ACK_1
        i2c_start();
        send_byte(8'h34, 1'b1, "t6r_ack_addr");
        for (int i = 7; i >= 0; i--) send_bit(i == 3);
        wait_n(4);
        chk(32'(sda_oe), 1, "t6r_ack1_driven");
        rst = 1'b1;
        wait_n(1);
        chk(32'(sda_oe), 0, "t6r_sda_released");
        chk(32'(err), 0, "t6r_err_cleared");
        rst = 1'b0;
        wait_n(2); sda_m = 1'b1; wait_n(H); scl = 1'b1; wait_n(H); scl = 1'b0;
        i2c_stop();
        rd_check(7'd1, 9'h000, "t6r_regfile_cleared");

        wait_n(4);
        chk(32'(exp_q.size()), 0, "scoreboard_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
